// File: rtl/mat_stream_driver.sv
// Stream engine for the mat_mul accelerator: sends A then B as one
// AXI-Stream packet and captures the result words into a local buffer.
module mat_stream_driver #(
    parameter int DIM_LOG    = 1,
    parameter int DIM        = 2 ** DIM_LOG,
    parameter int SIZE       = DIM * DIM,
    parameter int SIZE_LOG   = 2 * DIM_LOG,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_areset,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [SIZE_LOG-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [SIZE_LOG-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err_len,
    output logic [SIZE_LOG:0]       rx_count,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    output logic                    s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                    s00_axis_tlast,
    input  logic                    s00_axis_tvalid
);

    localparam logic [SIZE_LOG:0] LAST_BEAT = (SIZE_LOG + 1)'(2 * SIZE - 1);
    localparam logic [SIZE_LOG:0] LAST_RX   = (SIZE_LOG + 1)'(SIZE - 1);
    localparam logic [SIZE_LOG:0] ONE       = (SIZE_LOG + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RX
    } state_t;

    state_t                r_state;
    logic [SIZE_LOG:0]     r_tx_idx;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [SIZE_LOG:0]     r_rx_count;
    logic                  r_rx_done;
    logic                  r_done;
    logic                  r_err_len;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic [DATA_WIDTH-1:0] r_buf_a [SIZE];
    logic [DATA_WIDTH-1:0] r_buf_b [SIZE];
    logic [DATA_WIDTH-1:0] r_res   [SIZE];

    logic                  w_idle;
    logic                  w_s_tready;
    logic                  w_tx_hs;
    logic                  w_rx_hs;
    logic                  w_rx_at_last;
    logic                  w_rx_fin;
    logic                  w_rx_done_nxt;
    logic                  w_wr_ok;
    logic [SIZE_LOG:0]     w_tx_nxt;
    logic [SIZE_LOG-1:0]   w_nxt_addr;
    logic [DATA_WIDTH-1:0] w_nxt_beat;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_s_tready    = !w_idle && !r_rx_done;
    assign w_tx_hs       = r_tvalid && m00_axis_tready;
    assign w_rx_hs       = s00_axis_tvalid && w_s_tready;
    assign w_rx_at_last  = (r_rx_count == LAST_RX);
    assign w_rx_fin      = w_rx_hs && (s00_axis_tlast || w_rx_at_last);
    assign w_rx_done_nxt = r_rx_done || w_rx_fin;
    // A write arriving with an accepted start is dropped so the first
    // beat always reflects the buffer as it stood before the run.
    assign w_wr_ok       = w_idle && wr_en && !start;

    // Beat index i selects A for i < SIZE, else B; SIZE is a power of two
    // so the top index bit is the buffer select and the rest the address.
    assign w_tx_nxt   = r_tx_idx + ONE;
    assign w_nxt_addr = w_tx_nxt[SIZE_LOG-1:0];
    assign w_nxt_beat = w_tx_nxt[SIZE_LOG] ? r_buf_b[w_nxt_addr]
                                           : r_buf_a[w_nxt_addr];

    assign busy            = !w_idle;
    assign done            = r_done;
    assign err_len         = r_err_len;
    assign rx_count        = r_rx_count;
    assign rd_data         = r_rd_data;
    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tdata  = r_tdata;
    assign m00_axis_tlast  = r_tlast;
    assign m00_axis_tstrb  = '1;
    assign s00_axis_tready = w_s_tready;

    // Control FSM: tx sequencing, rx bookkeeping and status flags.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_state    <= ST_IDLE;
            r_tx_idx   <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
            r_rx_count <= '0;
            r_rx_done  <= 1'b0;
            r_done     <= 1'b0;
            r_err_len  <= 1'b0;
        end else begin
            if (w_rx_hs) begin
                r_rx_count <= r_rx_count + ONE;
                if (s00_axis_tlast != w_rx_at_last) begin
                    r_err_len <= 1'b1;
                end
                if (w_rx_fin) begin
                    r_rx_done <= 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_SEND;
                        r_tx_idx   <= '0;
                        r_tvalid   <= 1'b1;
                        r_tdata    <= r_buf_a[0];
                        r_tlast    <= (LAST_BEAT == '0);
                        r_rx_count <= '0;
                        r_rx_done  <= 1'b0;
                        r_done     <= 1'b0;
                        r_err_len  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_tx_hs) begin
                        if (r_tx_idx == LAST_BEAT) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            if (w_rx_done_nxt) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_WAIT_RX;
                            end
                        end else begin
                            r_tx_idx <= w_tx_nxt;
                            r_tdata  <= w_nxt_beat;
                            r_tlast  <= (w_tx_nxt == LAST_BEAT);
                        end
                    end
                end
                ST_WAIT_RX: begin
                    if (w_rx_done_nxt) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Source buffers: host writes, contents survive reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (w_wr_ok) begin
            if (wr_sel) begin
                r_buf_b[wr_addr] <= wr_data;
            end else begin
                r_buf_a[wr_addr] <= wr_data;
            end
        end
    end

    // Result buffer: one word per accepted rx beat, contents survive reset.
    always_ff @(posedge s00_axi_aclk) begin
        if (w_rx_hs) begin
            r_res[r_rx_count[SIZE_LOG-1:0]] <= s00_axis_tdata;
        end
    end

    // Registered host read of the result buffer.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_res[rd_addr];
        end
    end

endmodule

// File: doc/mat_stream_driver.md
Name: mat_stream_driver

Overview:
- Stream-side counterpart of the mat_mul accelerator: it drives the accelerator's AXI-Stream slave input and terminates its AXI-Stream master output.
- Holds local A and B source buffers, loaded by the host through a simple write port. On start it streams A then B (2*SIZE beats, tlast on the final beat), then captures SIZE result words into a result buffer.
- The host reads the result buffer through a read port. The block is used as the host-side stream engine and as the bench-side driver for the accelerator.

Parameters:
DIM_LOG, 1, matrix dimension in log2
DIM, 2**DIM_LOG, matrix dimension
SIZE, DIM*DIM, words per matrix
SIZE_LOG, 2*DIM_LOG, buffer address width
DATA_WIDTH, 32, word width

Ports:
s00_axi_aclk  in  1  sole clock; one clock, reset is synchronous and active-high
s00_axi_areset  in  1  synchronous active-high reset
wr_en  in  1  source buffer write strobe (honoured only in IDLE)
wr_sel  in  1  0 = buffer A, 1 = buffer B
wr_addr  in  SIZE_LOG  source word index
wr_data  in  DATA_WIDTH  source word
rd_addr  in  SIZE_LOG  result buffer index
rd_data  out  DATA_WIDTH  result word, registered
start  in  1  run request (honoured only in IDLE)
busy  out  1  high in SEND and WAIT_RX
done  out  1  sticky completion flag
err_len  out  1  sticky tlast-mismatch flag
rx_count  out  SIZE_LOG+1  result words captured
m00_axis_tvalid  out  1  to accelerator slave
m00_axis_tdata  out  DATA_WIDTH  registered beat data
m00_axis_tstrb  out  DATA_WIDTH/8  constant all ones
m00_axis_tlast  out  1  high on beat 2*SIZE-1 only
m00_axis_tready  in  1  from accelerator
s00_axis_tready  out  1  to accelerator master
s00_axis_tdata  in  DATA_WIDTH  result word
s00_axis_tlast  in  1  end of result stream
s00_axis_tvalid  in  1  from accelerator

Behaviour:
- Reset (sampled on the clock edge): state IDLE; tvalid, tlast, tdata, s00_axis_tready, busy, done, err_len, rd_data all 0; rx_count 0. Buffer contents are retained. A reset mid-operation aborts immediately; no further beats are presented.
- States:
  - IDLE: on start go to SEND; clear done, err_len, rx_count and the tx index.
  - SEND: advance on tx handshakes. On the handshake of beat 2*SIZE-1, go to WAIT_RX, or to IDLE if rx is already complete.
  - WAIT_RX: when rx completes, go to IDLE and set done=1.
- TX timing:
  - The edge after start is sampled: tvalid=1, tdata=A[0].
  - Beat i carries A[i] for i<SIZE, otherwise B[i-SIZE].
  - A handshake (tvalid&tready) at an edge loads the next beat at that same edge, giving 1 beat/cycle when tready is held high.
  - While tready=0, tvalid, tdata and tlast are held stable.
  - After the last handshake, tvalid=0 and tlast=0.
- RX:
  - s00_axis_tready=1 in SEND and WAIT_RX while rx is not complete; otherwise 0.
  - Each handshake writes R[rx_count] and increments rx_count.
  - tlast on word index SIZE-1: normal completion.
  - tlast on an earlier word: capture that word, set err_len, rx complete.
  - Word SIZE-1 arriving without tlast: capture it, set err_len, rx complete.
  - Rx completion can occur during SEND; done is raised only once tx is also finished.
- Host ports:
  - wr_en in IDLE writes the selected buffer at that edge.
  - wr_en while busy is ignored; wr_en in the same cycle as an accepted start is also ignored.
  - start while busy is ignored.
  - rd_data = R[rd_addr] one cycle after rd_addr is applied; valid in any state.
- Arithmetic: no arithmetic on data. The tx index counts to 2*SIZE-1 (SIZE_LOG+1 bits) and does not wrap past the last beat.

Test Plan:
- DIM_LOG=1, A={1,2,3,4}, B={5,6,7,8}, tready=1 -> 8 consecutive beats 1..8, tlast only with data 8. Sink returns 19,22,43,50 with tlast on the 4th -> done=1, err_len=0, rx_count=4; rd_addr 0..3 returns 19,22,43,50 with 1-cycle latency.
- Same data, m00_axis_tready alternating 1,0 -> tdata and tvalid held during every 0 cycle; exactly 8 beats in order 1..8; tlast asserted only with 8.
- Result tlast on the 2nd word -> err_len=1, rx_count=2, done=1 once tx finishes; s00_axis_tready drops after that word.
- Result stream without tlast on the 4th word -> err_len=1, rx_count=4, done=1.
- start and wr_en(A[0]=99) issued while busy -> both ignored; a second run resends A[0]=1. In IDLE, write A[0]=99 then start -> first beat 99.
- Reset asserted after 3 tx handshakes -> next cycle tvalid=0, busy=0, done=0, s00_axis_tready=0. A new start resends from A[0] and buffer data is unchanged.
